// File: rtl/cruise_sequencer.sv
// cruise_sequencer: cruise-control mode sequencer.
// Holds the set speed and tracks engagement. It drives brake and throttle
// requests toward the set speed. All outputs are registered.
// Optional feature macro CRUISE_DROWSY_EN adds the following when defined:
//   - driver alertness monitoring
//   - the DROWSY slowdown ramp
//   - the STOP state
// Without it the block only uses IDLE and CRUISE, and alarm is always 0.
module cruise_sequencer #(
    parameter int unsigned STEP      = 2,
    parameter int unsigned MIN_SET   = 30,
    parameter int unsigned MAX_SET   = 200,
    parameter int unsigned HYST      = 3,
    parameter int unsigned ALERT_MIN = 3,
    parameter int unsigned ALERT_CYC = 8,
    parameter int unsigned RAMP_DIV  = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] vfeli,
    input  logic [1:0] change,
    input  logic       brake_pedal,
    input  logic [2:0] hooshyari,
    output logic [7:0] vout,
    output logic [1:0] state,
    output logic       gt,
    output logic       eq,
    output logic       lt,
    output logic       tormoz,
    output logic [2:0] pashesh,
    output logic       alarm
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_CRUISE = 2'b01,
        S_DROWSY = 2'b10,
        S_STOP   = 2'b11
    } state_t;

    state_t     st_q, st_n;
    logic [7:0] vout_n;
    logic       gt_n, eq_n, lt_n, tormoz_n, alarm_n;
    logic [2:0] pashesh_n;

    // Set-speed increment that saturates at the top of the settable range.
    function automatic logic [7:0] step_up(input logic [7:0] v);
        logic [8:0] s;
        s = {1'b0, v} + 9'(STEP);
        return (s > 9'(MAX_SET)) ? 8'(MAX_SET) : s[7:0];
    endfunction

    // Set-speed decrement clamped at a caller-chosen floor.
    function automatic logic [7:0] step_down(input logic [7:0] v, input logic [7:0] floor_v);
        logic [8:0] lim;
        lim = {1'b0, floor_v} + 9'(STEP);
        return ({1'b0, v} < lim) ? floor_v : (v - 8'(STEP));
    endfunction

    function automatic logic in_range(input logic [7:0] v);
        return (v >= 8'(MIN_SET)) && (v <= 8'(MAX_SET));
    endfunction

    // Half the speed deficit, saturated to the 3-bit throttle range.
    function automatic logic [2:0] throttle(input logic [7:0] meas, input logic [7:0] set_v);
        logic [7:0] half;
        half = (set_v - meas) >> 1;
        if (meas >= set_v) return 3'd0;
        return (half > 8'd7) ? 3'd7 : half[2:0];
    endfunction

    // Overspeed compare done at 9 bits so set_v + HYST never wraps.
    function automatic logic overspeed(input logic [7:0] meas, input logic [7:0] set_v);
        return {1'b0, meas} > ({1'b0, set_v} + 9'(HYST));
    endfunction

`ifdef CRUISE_DROWSY_EN
    localparam int unsigned CW = $clog2(ALERT_CYC + 1);
    localparam int unsigned RW = $clog2(RAMP_DIV + 1);

    // acnt counts low-alert cycles in CRUISE and alert cycles in DROWSY.
    logic [CW-1:0] acnt_q, acnt_n, acnt_inc, acnt_sat;
    logic [RW-1:0] rcnt_q, rcnt_n, rcnt_inc;
    logic          low_alert, ramp_tick;

    assign low_alert = hooshyari < 3'(ALERT_MIN);
    assign acnt_inc  = acnt_q + CW'(1);
    assign acnt_sat  = (acnt_q == CW'(ALERT_CYC)) ? acnt_q : acnt_inc;
    assign rcnt_inc  = rcnt_q + RW'(1);
    assign ramp_tick = (rcnt_inc == RW'(RAMP_DIV));
`else
    logic unused_alert;
    assign unused_alert = ^{hooshyari, 32'(ALERT_MIN), 32'(ALERT_CYC), 32'(RAMP_DIV)};
`endif

    assign state = st_q;

    // Next state, next set speed and counter updates; brake > alertness > lever.
    always_comb begin
        st_n   = st_q;
        vout_n = vout;
`ifdef CRUISE_DROWSY_EN
        acnt_n = acnt_q;
        rcnt_n = rcnt_q;
`endif
        case (st_q)
            S_IDLE: begin
`ifdef CRUISE_DROWSY_EN
                acnt_n = '0;
`endif
                if (!brake_pedal && change == 2'b01 && in_range(vfeli)) begin
                    vout_n = vfeli;
                    st_n   = S_CRUISE;
                end
            end
            S_CRUISE: begin
                if (brake_pedal) begin
                    st_n = S_IDLE;
`ifdef CRUISE_DROWSY_EN
                    acnt_n = '0;
                end else if (low_alert && acnt_inc == CW'(ALERT_CYC)) begin
                    st_n   = S_DROWSY;
                    acnt_n = '0;
                    rcnt_n = '0;
`endif
                end else begin
`ifdef CRUISE_DROWSY_EN
                    acnt_n = low_alert ? acnt_inc : '0;
`endif
                    case (change)
                        2'b01:   if (in_range(vfeli)) vout_n = vfeli;
                        2'b10:   vout_n = step_up(vout);
                        2'b11:   vout_n = step_down(vout, 8'(MIN_SET));
                        default: vout_n = vout;
                    endcase
                end
            end
`ifdef CRUISE_DROWSY_EN
            S_DROWSY: begin
                if (brake_pedal) begin
                    st_n   = S_IDLE;
                    acnt_n = '0;
                end else begin
                    acnt_n = low_alert ? '0 : acnt_sat;
                    rcnt_n = ramp_tick ? '0 : rcnt_inc;
                    if (vfeli == 8'd0 && vout == 8'd0) begin
                        st_n = S_STOP;
                    end else if (acnt_n == CW'(ALERT_CYC) && vout >= 8'(MIN_SET)) begin
                        st_n   = S_CRUISE;
                        acnt_n = '0;
                    end else if (ramp_tick) begin
                        vout_n = step_down(vout, 8'd0);
                    end
                end
            end
            S_STOP: begin
                if (brake_pedal && !low_alert) st_n = S_IDLE;
            end
`endif
            default: st_n = S_IDLE;
        endcase
    end

    // Output values for the upcoming cycle, judged against the next set speed.
    always_comb begin
        gt_n      = vfeli > vout_n;
        eq_n      = vfeli == vout_n;
        lt_n      = vfeli < vout_n;
        tormoz_n  = 1'b0;
        pashesh_n = 3'd0;
        alarm_n   = 1'b0;
        case (st_n)
            S_CRUISE: begin
                tormoz_n  = overspeed(vfeli, vout_n);
                pashesh_n = throttle(vfeli, vout_n);
            end
`ifdef CRUISE_DROWSY_EN
            S_DROWSY: begin
                tormoz_n  = overspeed(vfeli, vout_n);
                pashesh_n = throttle(vfeli, vout_n);
                alarm_n   = 1'b1;
            end
            S_STOP: begin
                tormoz_n = 1'b1;
                alarm_n  = 1'b1;
            end
`endif
            default: begin
                tormoz_n  = 1'b0;
                pashesh_n = 3'd0;
            end
        endcase
    end

    // State, set speed, counters and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            st_q    <= S_IDLE;
            vout    <= 8'd0;
            gt      <= 1'b0;
            eq      <= 1'b1;
            lt      <= 1'b0;
            tormoz  <= 1'b0;
            pashesh <= 3'd0;
            alarm   <= 1'b0;
`ifdef CRUISE_DROWSY_EN
            acnt_q  <= '0;
            rcnt_q  <= '0;
`endif
        end else begin
            st_q    <= st_n;
            vout    <= vout_n;
            gt      <= gt_n;
            eq      <= eq_n;
            lt      <= lt_n;
            tormoz  <= tormoz_n;
            pashesh <= pashesh_n;
            alarm   <= alarm_n;
`ifdef CRUISE_DROWSY_EN
            acnt_q  <= acnt_n;
            rcnt_q  <= rcnt_n;
`endif
        end
    end

endmodule

// File: tb/tb_cruise_sequencer.sv
// Testbench for cruise_sequencer: directed table, multi-cycle sequences and
// randomized traffic compared against a behavioural model.
module tb_cruise_sequencer;

    localparam int STEP      = 2;
    localparam int MIN_SET   = 30;
    localparam int MAX_SET   = 200;
    localparam int HYST      = 3;
    localparam int ALERT_MIN = 3;
    localparam int ALERT_CYC = 8;
    localparam int RAMP_DIV  = 4;
`ifdef CRUISE_DROWSY_EN
    localparam bit DROWSY_EN = 1'b1;
`else
    localparam bit DROWSY_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] vfeli = 8'd0;
    logic [1:0] change = 2'd0;
    logic       brake_pedal = 1'b0;
    logic [2:0] hooshyari = 3'd7;
    logic [7:0] vout;
    logic [1:0] state;
    logic       gt, eq, lt, tormoz, alarm;
    logic [2:0] pashesh;

    int n_tests = 0;
    int n_fail  = 0;

    // model state: mode, set speed, last sampled speed, run lengths, drowsy age
    int m_st, m_vout, m_vf, m_low, m_alert, m_age;

    cruise_sequencer dut (
        .clock(clock), .reset_n(reset_n), .vfeli(vfeli), .change(change),
        .brake_pedal(brake_pedal), .hooshyari(hooshyari), .vout(vout),
        .state(state), .gt(gt), .eq(eq), .lt(lt), .tormoz(tormoz),
        .pashesh(pashesh), .alarm(alarm)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        int vf, ch, bp;
        int vo, st, g, e, l, t, p;
    } vec_t;

    vec_t tbl[23];

    function automatic logic [31:0] pack(input int vo, input int st, input int g, input int e,
                                         input int l, input int t, input int p, input int a);
        return 32'({8'(vo), 2'(st), 1'(g), 1'(e), 1'(l), 1'(t), 3'(p), 1'(a)});
    endfunction

    function automatic logic [31:0] dut_word();
        return 32'({vout, state, gt, eq, lt, tormoz, pashesh, alarm});
    endfunction

    function automatic logic [31:0] model_word();
        int t, p, a;
        bit active;
        active = (m_st == 1) || (m_st == 2);
        t = (m_st == 3) ? 1 : ((active && m_vf > m_vout + HYST) ? 1 : 0);
        p = 0;
        if (active && m_vf < m_vout) p = ((m_vout - m_vf) / 2 > 7) ? 7 : (m_vout - m_vf) / 2;
        a = (m_st >= 2) ? 1 : 0;
        return pack(m_vout, m_st, int'(m_vf > m_vout), int'(m_vf == m_vout),
                    int'(m_vf < m_vout), t, p, a);
    endfunction

    task automatic m_reset();
        m_st = 0; m_vout = 0; m_vf = 0; m_low = 0; m_alert = 0; m_age = 0;
    endtask

    task automatic model_step(input int vf, input int ch, input int bp, input int h);
        bit low;
        int ns, nv;
        low = (h < ALERT_MIN);
        ns  = m_st;
        nv  = m_vout;
        case (m_st)
            0: begin
                m_low = 0;
                if (bp == 0 && ch == 1 && vf >= MIN_SET && vf <= MAX_SET) begin
                    nv = vf; ns = 1;
                end
            end
            1: begin
                if (bp != 0) begin
                    ns = 0; m_low = 0;
                end else begin
                    if (DROWSY_EN) m_low = low ? m_low + 1 : 0;
                    if (DROWSY_EN && m_low >= ALERT_CYC) begin
                        ns = 2; m_low = 0; m_alert = 0; m_age = 0;
                    end else if (ch == 1) begin
                        if (vf >= MIN_SET && vf <= MAX_SET) nv = vf;
                    end else if (ch == 2) begin
                        nv = (m_vout + STEP > MAX_SET) ? MAX_SET : m_vout + STEP;
                    end else if (ch == 3) begin
                        nv = (m_vout - STEP < MIN_SET) ? MIN_SET : m_vout - STEP;
                    end
                end
            end
            2: begin
                if (bp != 0) begin
                    ns = 0; m_low = 0;
                end else begin
                    m_alert = low ? 0 : m_alert + 1;
                    m_age++;
                    if (vf == 0 && m_vout == 0) ns = 3;
                    else if (m_alert >= ALERT_CYC && m_vout >= MIN_SET) begin
                        ns = 1; m_low = 0;
                    end else if (m_age % RAMP_DIV == 0) begin
                        nv = (m_vout - STEP < 0) ? 0 : m_vout - STEP;
                    end
                end
            end
            default: begin
                if (bp != 0 && !low) ns = 0;
            end
        endcase
        m_st   = ns;
        m_vout = nv;
        m_vf   = vf;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input int vf, input int ch, input int bp, input int h);
        vfeli       = 8'(vf);
        change      = 2'(ch);
        brake_pedal = 1'(bp);
        hooshyari   = 3'(h);
        @(posedge clock);
        #1;
        model_step(vf, ch, bp, h);
    endtask

    task automatic mid_reset(input string name);
        reset_n = 1'b0;
        #2;
        chk(name, dut_word(), pack(0, 0, 0, 1, 0, 0, 0, 0));
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        m_reset();
    endtask

    initial begin
        int vf, ch, bp, h;
        // vf, ch, bp, vout, state, gt, eq, lt, tormoz, pashesh
        tbl[0]  = '{20,  1, 0,   0, 0, 1, 0, 0, 0, 0};
        tbl[1]  = '{136, 1, 0, 136, 1, 0, 1, 0, 0, 0};
        tbl[2]  = '{136, 2, 0, 138, 1, 0, 0, 1, 0, 1};
        tbl[3]  = '{136, 2, 0, 140, 1, 0, 0, 1, 0, 2};
        tbl[4]  = '{136, 2, 0, 142, 1, 0, 0, 1, 0, 3};
        tbl[5]  = '{32,  1, 0,  32, 1, 0, 1, 0, 0, 0};
        tbl[6]  = '{32,  3, 0,  30, 1, 1, 0, 0, 0, 0};
        tbl[7]  = '{32,  3, 0,  30, 1, 1, 0, 0, 0, 0};
        tbl[8]  = '{100, 1, 0, 100, 1, 0, 1, 0, 0, 0};
        tbl[9]  = '{90,  0, 0, 100, 1, 0, 0, 1, 0, 5};
        tbl[10] = '{104, 0, 0, 100, 1, 1, 0, 0, 1, 0};
        tbl[11] = '{103, 0, 0, 100, 1, 1, 0, 0, 0, 0};
        tbl[12] = '{200, 1, 0, 200, 1, 0, 1, 0, 0, 0};
        tbl[13] = '{200, 2, 0, 200, 1, 0, 1, 0, 0, 0};
        tbl[14] = '{201, 1, 0, 200, 1, 1, 0, 0, 0, 0};
        tbl[15] = '{250, 0, 0, 200, 1, 1, 0, 0, 1, 0};
        tbl[16] = '{50,  1, 0,  50, 1, 0, 1, 0, 0, 0};
        tbl[17] = '{50,  2, 1,  50, 0, 0, 1, 0, 0, 0};
        tbl[18] = '{10,  1, 0,  50, 0, 0, 0, 1, 0, 0};
        tbl[19] = '{60,  1, 1,  50, 0, 1, 0, 0, 0, 0};
        tbl[20] = '{60,  1, 0,  60, 1, 0, 1, 0, 0, 0};
        tbl[21] = '{40,  0, 0,  60, 1, 0, 0, 1, 0, 7};
        tbl[22] = '{59,  0, 0,  60, 1, 0, 0, 1, 0, 0};

        // reset
        m_reset();
        repeat (2) @(posedge clock);
        #1;
        chk("reset_values", dut_word(), pack(0, 0, 0, 1, 0, 0, 0, 0));
        reset_n = 1'b1;

        // directed table
        for (int i = 0; i < 23; i++) begin
            apply(tbl[i].vf, tbl[i].ch, tbl[i].bp, 7);
            chk($sformatf("vec%0d", i), dut_word(),
                pack(tbl[i].vo, tbl[i].st, tbl[i].g, tbl[i].e, tbl[i].l, tbl[i].t, tbl[i].p, 0));
        end

`ifdef CRUISE_DROWSY_EN
        // drowsy entry, ramp and return
        apply(50, 1, 0, 7);
        chk("cap50", dut_word(), model_word());
        for (int i = 1; i <= 8; i++) begin
            apply(50, 0, 0, 2);
            chk($sformatf("low%0d_state", i), 32'(state), (i < 8) ? 32'd1 : 32'd2);
        end
        chk("drowsy_alarm", 32'(alarm), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            apply(50, 0, 0, 2);
            chk($sformatf("ramp%0d_vout", i), 32'(vout), 32'(50 - 2 * (i / 4)));
        end
        for (int i = 1; i <= 8; i++) begin
            apply(50, 0, 0, 6);
            chk($sformatf("alert%0d_state", i), 32'(state), (i < 8) ? 32'd2 : 32'd1);
        end
        chk("return_vout", 32'(vout), 32'd44);
        chk("return_model", dut_word(), model_word());

        // ramp to zero and STOP
        apply(30, 1, 0, 7);
        for (int i = 0; i < 8; i++) apply(30, 0, 0, 2);
        chk("drowsy30", 32'(state), 32'd2);
        for (int k = 0; k < 200 && state != 2'b11; k++) begin
            apply(0, 0, 0, 0);
            chk($sformatf("ramp0_%0d", k), dut_word(), model_word());
        end
        chk("stop_reached", 32'(state), 32'd3);
        chk("stop_outputs", 32'({tormoz, pashesh, alarm}), 32'b1_000_1);
        apply(0, 0, 1, 2);
        chk("stop_hold", 32'(state), 32'd3);
        apply(0, 0, 1, 6);
        chk("stop_exit", dut_word(), model_word());
        chk("stop_exit_state", 32'(state), 32'd0);

        // asynchronous reset while drowsy
        apply(50, 1, 0, 7);
        for (int i = 0; i < 11; i++) apply(50, 0, 0, 1);
        chk("pre_reset_drowsy", 32'(state), 32'd2);
        mid_reset("reset_mid_drowsy");
`else
        // alertness has no effect in this build
        apply(50, 1, 0, 7);
        for (int i = 0; i < 20; i++) begin
            apply(50, 0, 0, 2);
            chk($sformatf("nodrowsy%0d", i), dut_word(), model_word());
        end
        chk("nodrowsy_state", 32'({state, alarm}), 32'b01_0);
        mid_reset("reset_mid_cruise");
`endif

        // randomized traffic against the model
        h = 7;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 15) == 0) h = int'($urandom_range(0, 7));
            if (m_st == 2 && $urandom_range(0, 3) == 0) vf = 0;
            else if ($urandom_range(0, 3) == 0) vf = int'($urandom_range(0, 255));
            else begin
                vf = m_vout + int'($urandom_range(0, 16)) - 8;
                if (vf < 0) vf = 0;
                if (vf > 255) vf = 255;
            end
            ch = int'($urandom_range(0, 3));
            bp = ($urandom_range(0, 40) == 0) ? 1 : 0;
            apply(vf, ch, bp, h);
            chk($sformatf("rand%0d", c), dut_word(), model_word());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cruise_sequencer.md
# cruise_sequencer

Mode sequencer for the cruise-control datapath. It holds the driver's set speed and tracks engagement, driver alertness and the drowsy-slowdown sequence. Each cycle it compares the measured speed against the set speed and drives the brake (`tormoz`) and throttle level (`pashesh`) toward that set speed. It sits between the driver controls (pedal, lever, alertness sensor) and the actuator stage.

## Interface
Parameters:
- `STEP`, 2: set-speed increment/decrement per lever command and per ramp tick.
- `MIN_SET`, 30: lowest speed that may be captured or coasted to.
- `MAX_SET`, 200: highest set speed; accelerate saturates here.
- `HYST`, 3: overspeed margin before brake asserts.
- `ALERT_MIN`, 3: `hooshyari` values below this count as drowsy.
- `ALERT_CYC`, 8: consecutive cycles needed to enter or leave drowsy handling.
- `RAMP_DIV`, 4: cycles between set-speed decrements while drowsy.

Ports:
- `clock` in 1: single rising-edge clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `vfeli` in 8: measured current speed, unsigned.
- `change` in 2: lever command; 00 none, 01 set, 10 accelerate, 11 coast.
- `brake_pedal` in 1: driver brake, level.
- `hooshyari` in 3: driver alertness, 0 = asleep, 7 = fully alert.
- `vout` out 8: current set speed.
- `state` out 2: 00 IDLE, 01 CRUISE, 10 DROWSY, 11 STOP.
- `gt` / `eq` / `lt` out 1 each: registered compare of `vfeli` against `vout`; exactly one is high.
- `tormoz` out 1: brake request.
- `pashesh` out 3: throttle level 0–7.
- `alarm` out 1: driver warning.

## Operation
- Priority each edge: reset, then `brake_pedal`, then alertness, then `change`.
- IDLE:
  - `tormoz`=0, `pashesh`=0, `vout` is held.
  - `change`=01 with `vfeli`≥MIN_SET and `vfeli`≤MAX_SET: `vout`←`vfeli`, go to CRUISE.
  - Any other capture attempt is ignored.
- CRUISE:
  - `change`=10: `vout`←min(`vout`+STEP, MAX_SET).
  - `change`=11: `vout`←max(`vout`−STEP, MIN_SET).
  - `change`=01: re-captures `vfeli` under the same range rule.
  - Throttle: if `vfeli`<`vout`, `pashesh`=min(7, (`vout`−`vfeli`)>>1); otherwise 0.
  - `tormoz`=1 iff `vfeli`>`vout`+HYST; this compare is 9-bit, no wrap.
- `brake_pedal`=1 in CRUISE or DROWSY: go to IDLE and clear the alert counter; `vout` is retained.
- Alert counter:
  - Counts consecutive cycles with `hooshyari`<ALERT_MIN and resets on any alert cycle.
  - Reaching ALERT_CYC in CRUISE: go to DROWSY.
- DROWSY:
  - `alarm`=1 and `change` is ignored.
  - Every RAMP_DIV cycles, `vout`←max(`vout`−STEP, 0), with a floor of 0, not MIN_SET.
  - Throttle and brake follow the CRUISE rules against the ramping `vout`.
  - ALERT_CYC consecutive alert cycles with `vout`≥MIN_SET: return to CRUISE holding the current `vout`.
  - `vfeli`=0 and `vout`=0: go to STOP.
- STOP:
  - `tormoz`=1, `pashesh`=0, `alarm`=1.
  - Leaves to IDLE only when `brake_pedal`=1 and `hooshyari`≥ALERT_MIN in the same cycle.

## Timing
- All outputs are registered: one cycle of latency from sampled inputs to outputs.
- Reset values: `vout`=0, `state`=IDLE, `eq`=1 (`vfeli` is treated as 0), `gt`=`lt`=0, `tormoz`=0, `pashesh`=0, `alarm`=0. The alert counter and ramp counter are 0.
- Reset asserted mid-operation returns every output to its reset value immediately, without waiting for a clock edge.
- Commands are level-sampled every cycle; a lever held for N cycles applies N steps.
- The ramp counter restarts on DROWSY entry. The first decrement occurs RAMP_DIV cycles after entry.
- When `brake_pedal` and `change` are both asserted in the same cycle, the brake wins and the command is dropped.

## Configuration
- `CRUISE_DROWSY_EN`:
  - Defined: alertness monitoring, DROWSY and STOP are implemented as described.
  - Undefined: `hooshyari` is ignored, the counters are removed, `state` never leaves {IDLE, CRUISE`}`, and `alarm` is tied 0.

## Test plan
- Reset then `vfeli`=136, `change`=01: next cycle `state`=CRUISE, `vout`=136, `eq`=1, `pashesh`=0, `tormoz`=0.
- In CRUISE at `vout`=136, hold `change`=10 for 3 cycles: `vout`=142. Hold 11 from `vout`=32 for 2 cycles: `vout`=30 (floor).
- `vout`=100 with `vfeli`=90: `lt`=1, `pashesh`=5. Then `vfeli`=104: `gt`=1, `tormoz`=1. Then `vfeli`=103: `tormoz`=0.
- `hooshyari`=2 for 8 cycles in CRUISE: DROWSY with `alarm`=1; `vout` drops by 2 every 4 cycles. `hooshyari`=6 for 8 cycles with `vout`≥30: CRUISE.
- Drowsy ramp to `vout`=0 with `vfeli`=0: STOP with `tormoz`=1. `brake_pedal`=1 with `hooshyari`=2: stays STOP. `brake_pedal`=1 with `hooshyari`=6: IDLE.
- `brake_pedal`=1 together with `change`=10 in CRUISE at `vout`=50: IDLE, `vout`=50. Then drop `reset_n` mid-DROWSY: all outputs take their reset values.
